// File: rtl/mesi_bus_pkg.sv
// Shared types and width helpers for the L1 bus arbiter.
// Imported by the interface, the picker and the arbiter top.
package mesi_bus_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tenure counter must hold the value MAX_TENURE itself.
    function automatic int cnt_w(input int m);
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

    localparam int MAX_IDX_W = idx_w(MAX_REQ);

    typedef logic [MAX_REQ-1:0]   grant_oh_t;
    typedef logic [MAX_IDX_W-1:0] grant_idx_t;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the L1 ports and the bus arbiter.
// master = requester side, slave = arbiter side.
interface bus_arbiter_rr_if
    import mesi_bus_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]        bus_req;
    logic [NUM_REQ-1:0]        bus_lock;
    logic                      fixed_prio;
    logic [NUM_REQ-1:0]        bus_grant;
    logic [idx_w(NUM_REQ)-1:0] grant_id;
    logic                      bus_busy;
    logic                      preempt_pulse;

    modport master (
        output bus_req, bus_lock, fixed_prio,
        input  bus_grant, grant_id, bus_busy, preempt_pulse
    );

    modport slave (
        input  bus_req, bus_lock, fixed_prio,
        output bus_grant, grant_id, bus_busy, preempt_pulse
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational winner select: round-robin from a pointer or
// lowest-index first, after masking out excluded ports.
module rr_pick
    import mesi_bus_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [idx_w(NUM_REQ)-1:0] ptr_i,
    input  arb_mode_e                 mode_i,
    input  logic [NUM_REQ-1:0]        excl_i,
    output logic [NUM_REQ-1:0]        oh_o,
    output logic [idx_w(NUM_REQ)-1:0] idx_o,
    output logic                      valid_o
);

    localparam int IW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0] cand;
    int                 k;

    assign cand = req_i & ~excl_i;

    always_comb begin
        oh_o    = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mode_i == ARB_FIXED) k = i;
            else                     k = (int'(ptr_i) + i) % NUM_REQ;
            if (!valid_o && cand[k]) begin
                valid_o = 1'b1;
                oh_o[k] = 1'b1;
                idx_o   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// L1 bus arbiter: registered one-hot grant, round-robin or fixed
// priority, with tenure-limit preemption gated by the owner's lock.
module bus_arbiter_rr
    import mesi_bus_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_TENURE = 16
) (
    input logic             clk,
    input logic             reset,
    bus_arbiter_rr_if.slave bus
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int TW = cnt_w(MAX_TENURE);
    localparam logic [TW-1:0] TEN_MAX  = TW'(MAX_TENURE);
    localparam logic [TW-1:0] TEN_LAST =
        TW'((MAX_TENURE > 0) ? MAX_TENURE - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      id_q, id_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [TW-1:0]      ten_q, ten_d;
    logic               pulse_q, pulse_d;

    arb_mode_e          mode;
    logic               holding, others, expired, preempt;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               pick_vld;

    assign mode    = bus.fixed_prio ? ARB_FIXED : ARB_RR;
    assign holding = |(grant_q & bus.bus_req);
    assign others  = |(bus.bus_req & ~grant_q);
    assign expired = (MAX_TENURE != 0) && (ten_q >= TEN_LAST);
    assign preempt = holding && expired && others &&
                     !(|(grant_q & bus.bus_lock));

    // Excluding the owner only matters on preemption; a releasing
    // owner has its request low anyway.
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (bus.bus_req),
        .ptr_i   (ptr_q),
        .mode_i  (mode),
        .excl_i  (grant_q),
        .oh_o    (pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    always_comb begin
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        ten_d   = ten_q;
        pulse_d = 1'b0;
        if (holding && !preempt) begin
            if (ten_q != TEN_MAX) ten_d = ten_q + TW'(1);
        end else begin
            grant_d = pick_oh;
            id_d    = pick_idx;
            ten_d   = '0;
            pulse_d = preempt;
            if (pick_vld && mode == ARB_RR) begin
                ptr_d = (pick_idx == IDX_LAST) ? '0 : pick_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            ten_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            ten_q   <= ten_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.bus_grant     = grant_q;
    assign bus.grant_id      = id_q;
    assign bus.bus_busy      = |grant_q;
    assign bus.preempt_pulse = pulse_q;

endmodule
